// File: rtl/gray_seq_pkg.sv
// Shared opcodes, FSM state encoding and direction values for the Gray counter sequencer.
// Pure definitions: no logic, so no latency or backpressure of its own.
package gray_seq_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_START   = 3'd1;
  localparam logic [2:0] OP_STOP    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_LOAD    = 3'd4;
  localparam logic [2:0] OP_DIR     = 3'd5;
  localparam logic [2:0] OP_ONESHOT = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_ONESHOT = 2'd2,
    ST_STEP    = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-CLOCK_MHZ counter; tick is combinational on the terminal cycle.
// clear has priority over enable and forces the phase back to 0; no backpressure.
module tick_prescaler #(
  parameter int CLOCK_MHZ      = 16,
  parameter int CLOCK_MHZ_BITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [CLOCK_MHZ_BITS-1:0] TERM = CLOCK_MHZ_BITS'(CLOCK_MHZ - 1);

  logic [CLOCK_MHZ_BITS-1:0] cnt_q;

  assign tick = enable && (cnt_q == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + CLOCK_MHZ_BITS'(1);
    end
  end

endmodule

// File: rtl/gray_counter_sequencer.sv
// Command-driven Gray counter: RUN/ONESHOT/STEP modes, tick/bin/gray/wrap registered together one cycle after terminal count.
// cmd_ready drops only while a single STEP is in flight; STOP/LOAD on the terminal cycle suppress that tick.
module gray_counter_sequencer
  import gray_seq_pkg::*;
#(
  parameter int CLOCK_MHZ      = 16,
  parameter int CLOCK_MHZ_BITS = 4,
  parameter int BITS           = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [BITS-1:0] cmd_data,
  output logic            running,
  output logic            tick,
  output logic [BITS-1:0] bin_out,
  output logic [BITS-1:0] gray_out,
  output logic            wrap
);

  state_t          state_q, state_d;
  logic            dir_q, dir_d;
  logic [BITS-1:0] bin_q, bin_d;
  logic [BITS-1:0] gray_q, gray_d;
  logic [BITS-1:0] bin_step;
  logic            tick_q, wrap_q;
  logic            presc_tc, presc_en, presc_clr;
  logic            cmd_acc;
  logic            op_start, op_stop, op_step, op_load, op_dir, op_oneshot;
  logic            count_now, wrap_now;

  assign cmd_ready = (state_q != ST_STEP);
  assign running   = (state_q == ST_RUN) || (state_q == ST_ONESHOT);
  assign cmd_acc   = cmd_valid && cmd_ready;

  always_comb begin
    op_start   = 1'b0;
    op_stop    = 1'b0;
    op_step    = 1'b0;
    op_load    = 1'b0;
    op_dir     = 1'b0;
    op_oneshot = 1'b0;
    if (cmd_acc) begin
      case (cmd_op)
        OP_START:   op_start   = 1'b1;
        OP_STOP:    op_stop    = 1'b1;
        OP_STEP:    op_step    = 1'b1;
        OP_LOAD:    op_load    = 1'b1;
        OP_DIR:     op_dir     = 1'b1;
        OP_ONESHOT: op_oneshot = 1'b1;
        default:    ;
      endcase
    end
  end

  // A STOP or LOAD landing on the terminal cycle swallows that tick entirely.
  assign count_now = presc_tc && !op_stop && !op_load;
  assign bin_step  = (dir_q == DIR_DOWN) ? bin_q - BITS'(1) : bin_q + BITS'(1);
  assign wrap_now  = count_now &&
                     ((dir_q == DIR_UP) ? (bin_q == {BITS{1'b1}}) : (bin_q == '0));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    bin_d   = bin_q;

    case (state_q)
      ST_IDLE: begin
        if (op_start)        state_d = ST_RUN;
        else if (op_oneshot) state_d = ST_ONESHOT;
        else if (op_step)    state_d = ST_STEP;
      end
      ST_RUN: begin
        if (op_stop)         state_d = ST_IDLE;
        else if (op_oneshot) state_d = ST_ONESHOT;
      end
      ST_ONESHOT: begin
        if (op_stop)         state_d = ST_IDLE;
        else if (op_start)   state_d = ST_RUN;
        else if (wrap_now)   state_d = ST_IDLE;
      end
      ST_STEP: begin
        if (count_now)       state_d = ST_IDLE;
      end
      default:               state_d = ST_IDLE;
    endcase

    // Direction change takes effect from the next tick; this tick used dir_q.
    if (op_dir) dir_d = cmd_data[0];

    if (op_load)        bin_d = cmd_data;
    else if (count_now) bin_d = bin_step;

    gray_d = bin_d ^ (bin_d >> 1);
  end

  // Prescaler is pinned at 0 whenever we are (or are about to be) idle, and re-phased by LOAD.
  assign presc_en  = (state_q != ST_IDLE);
  assign presc_clr = (state_d == ST_IDLE) || op_load;

  tick_prescaler #(
    .CLOCK_MHZ      (CLOCK_MHZ),
    .CLOCK_MHZ_BITS (CLOCK_MHZ_BITS)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (presc_en),
    .clear  (presc_clr),
    .tick   (presc_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      bin_q   <= '0;
      gray_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      tick_q  <= count_now;
      wrap_q  <= wrap_now;
    end
  end

  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign bin_out  = bin_q;
  assign gray_out = gray_q;

endmodule

// File: tb/tb_gray_counter_sequencer.sv
// Directed bench for gray_counter_sequencer: drives and samples on the falling edge.
module tb_gray_counter_sequencer;

  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [BITS-1:0] cmd_data;
  logic            running;
  logic            tick;
  logic [BITS-1:0] bin_out;
  logic [BITS-1:0] gray_out;
  logic            wrap;

  int total = 0;
  int bad   = 0;

  gray_counter_sequencer #(
    .CLOCK_MHZ      (16),
    .CLOCK_MHZ_BITS (4),
    .BITS           (BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .running   (running),
    .tick      (tick),
    .bin_out   (bin_out),
    .gray_out  (gray_out),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present one command at the current falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [2:0] op, input logic [BITS-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick && cyc < 40);
  endtask

  task automatic count_ticks(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tick) ticks++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
    #12;
    total++; if (bin_out !== 8'h00) begin bad++; $display("FAIL reset_bin got=%h exp=00", bin_out); end
    total++; if (gray_out !== 8'h00) begin bad++; $display("FAIL reset_gray got=%h exp=00", gray_out); end
    total++; if ({tick, wrap, running, cmd_ready} !== 4'b0001) begin bad++; $display("FAIL reset_flags got=%b exp=0001", {tick, wrap, running, cmd_ready}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start();
    int cyc;
    do_reset();
    send(3'd1, 8'h00);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running got=%b exp=1", running); end
    wait_tick(cyc);
    total++; if (cyc !== 16) begin bad++; $display("FAIL start_first_tick cycles got=%0d exp=16", cyc); end
    total++; if ({bin_out, gray_out} !== {8'h01, 8'h01}) begin bad++; $display("FAIL start_tick1 got=%h/%h exp=01/01", bin_out, gray_out); end
    wait_tick(cyc);
    total++; if (cyc !== 16) begin bad++; $display("FAIL start_spacing2 got=%0d exp=16", cyc); end
    total++; if ({bin_out, gray_out} !== {8'h02, 8'h03}) begin bad++; $display("FAIL start_tick2 got=%h/%h exp=02/03", bin_out, gray_out); end
    wait_tick(cyc);
    total++; if (cyc !== 16) begin bad++; $display("FAIL start_spacing3 got=%0d exp=16", cyc); end
    total++; if ({bin_out, gray_out, wrap} !== {8'h03, 8'h02, 1'b0}) begin bad++; $display("FAIL start_tick3 got=%h/%h/%b exp=03/02/0", bin_out, gray_out, wrap); end
  endtask

  task automatic test_oneshot();
    int cyc;
    int ticks;
    do_reset();
    send(3'd4, 8'hFE);
    total++; if ({bin_out, gray_out} !== {8'hFE, 8'h81}) begin bad++; $display("FAIL oneshot_load got=%h/%h exp=FE/81", bin_out, gray_out); end
    send(3'd6, 8'h00);
    wait_tick(cyc);
    total++; if ({cyc[7:0], bin_out, gray_out, wrap, running} !== {8'd16, 8'hFF, 8'h80, 1'b0, 1'b1}) begin bad++; $display("FAIL oneshot_ff cyc=%0d got=%h/%h wrap=%b run=%b exp=16 FF/80 0 1", cyc, bin_out, gray_out, wrap, running); end
    wait_tick(cyc);
    total++; if ({cyc[7:0], bin_out, gray_out, wrap, running} !== {8'd16, 8'h00, 8'h00, 1'b1, 1'b0}) begin bad++; $display("FAIL oneshot_wrap cyc=%0d got=%h/%h wrap=%b run=%b exp=16 00/00 1 0", cyc, bin_out, gray_out, wrap, running); end
    count_ticks(40, ticks);
    total++; if ({ticks[7:0], bin_out} !== {8'd0, 8'h00}) begin bad++; $display("FAIL oneshot_idle ticks=%0d bin=%h exp=0 00", ticks, bin_out); end
  endtask

  task automatic test_step();
    int low;
    do_reset();
    send(3'd5, 8'h01);
    send(3'd4, 8'h00);
    send(3'd3, 8'h00);
    low = 0;
    while (!cmd_ready && low < 40) begin
      low++;
      @(negedge clk);
    end
    total++; if (low !== 16) begin bad++; $display("FAIL step_ready_low cycles got=%0d exp=16", low); end
    total++; if ({bin_out, gray_out, wrap, tick, running} !== {8'hFF, 8'h80, 1'b1, 1'b1, 1'b0}) begin bad++; $display("FAIL step_result got=%h/%h wrap=%b tick=%b run=%b exp=FF/80 1 1 0", bin_out, gray_out, wrap, tick, running); end
  endtask

  task automatic test_stop_on_terminal();
    int cyc;
    int ticks;
    do_reset();
    send(3'd1, 8'h00);
    wait_tick(cyc);
    repeat (15) @(negedge clk);
    send(3'd2, 8'h00);
    total++; if ({tick, wrap, running, bin_out, gray_out} !== {3'b000, 8'h01, 8'h01}) begin bad++; $display("FAIL stop_terminal tick=%b wrap=%b run=%b got=%h/%h exp=0 0 0 01/01", tick, wrap, running, bin_out, gray_out); end
    count_ticks(20, ticks);
    total++; if ({ticks[7:0], bin_out} !== {8'd0, 8'h01}) begin bad++; $display("FAIL stop_idle ticks=%0d bin=%h exp=0 01", ticks, bin_out); end
  endtask

  task automatic test_load_on_terminal();
    int cyc;
    do_reset();
    send(3'd1, 8'h00);
    wait_tick(cyc);
    repeat (15) @(negedge clk);
    send(3'd4, 8'h10);
    total++; if ({tick, wrap, running, bin_out, gray_out} !== {3'b001, 8'h10, 8'h18}) begin bad++; $display("FAIL load_terminal tick=%b wrap=%b run=%b got=%h/%h exp=0 0 1 10/18", tick, wrap, running, bin_out, gray_out); end
    wait_tick(cyc);
    total++; if ({cyc[7:0], bin_out, gray_out} !== {8'd16, 8'h11, 8'h19}) begin bad++; $display("FAIL load_next cyc=%0d got=%h/%h exp=16 11/19", cyc, bin_out, gray_out); end
  endtask

  task automatic test_dir_on_terminal();
    int cyc;
    do_reset();
    send(3'd1, 8'h00);
    wait_tick(cyc);
    repeat (15) @(negedge clk);
    send(3'd5, 8'h01);
    total++; if ({tick, bin_out} !== {1'b1, 8'h02}) begin bad++; $display("FAIL dir_terminal tick=%b bin=%h exp=1 02", tick, bin_out); end
    wait_tick(cyc);
    total++; if ({cyc[7:0], bin_out, gray_out} !== {8'd16, 8'h01, 8'h01}) begin bad++; $display("FAIL dir_next cyc=%0d got=%h/%h exp=16 01/01", cyc, bin_out, gray_out); end
  endtask

  task automatic test_reset_mid_run();
    int ticks;
    do_reset();
    send(3'd4, 8'h37);
    send(3'd1, 8'h00);
    repeat (10) @(negedge clk);
    total++; if ({running, bin_out} !== {1'b1, 8'h37}) begin bad++; $display("FAIL midrun_pre run=%b bin=%h exp=1 37", running, bin_out); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({bin_out, gray_out, tick, wrap, running, cmd_ready} !== {8'h00, 8'h00, 4'b0001}) begin bad++; $display("FAIL midrun_async got=%h/%h flags=%b exp=00/00 0001", bin_out, gray_out, {tick, wrap, running, cmd_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    count_ticks(30, ticks);
    total++; if ({ticks[7:0], running, bin_out} !== {8'd0, 1'b0, 8'h00}) begin bad++; $display("FAIL midrun_after ticks=%0d run=%b bin=%h exp=0 0 00", ticks, running, bin_out); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_oneshot();
    test_step();
    test_stop_on_terminal();
    test_load_on_terminal();
    test_dir_on_terminal();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_counter_sequencer.md
Name: gray_counter_sequencer

Overview:
Command-driven controller that sequences a Gray-code counter. It owns the 1 MHz tick prescaler, the binary count register and its registered Gray conversion. Accepts start/stop/single-step/load/direction/one-shot commands over a valid/ready interface. Sits between a host/debug command source and the GRAY_OUT pins of the board top level.

Parameters:
CLOCK_MHZ, 16, input clock frequency in MHz; tick period = CLOCK_MHZ cycles
CLOCK_MHZ_BITS, 4, prescaler width; must equal clog2(CLOCK_MHZ)
BITS, 8, counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted this cycle
cmd_op  in  3  opcode: 0 NOP, 1 START, 2 STOP, 3 STEP, 4 LOAD, 5 DIR, 6 ONESHOT, 7 reserved (treated as NOP)
cmd_data  in  BITS  LOAD value (binary); DIR uses bit 0 (0 = up, 1 = down)
running  out  1  high in RUN or ONESHOT state
tick  out  1  one-cycle pulse on every prescaler terminal count while counting
bin_out  out  BITS  registered binary count
gray_out  out  BITS  registered Gray code of bin_out, same-cycle consistent
wrap  out  1  one-cycle pulse when the count wraps (up: max->0; down: 0->max)

Behaviour:
- Clock clk; reset asynchronous, active-low (rst_n). On reset: state IDLE, prescaler 0, bin_out 0, gray_out 0, dir up, tick 0, wrap 0, running 0, cmd_ready 1.
- Handshake: command accepted when cmd_valid && cmd_ready. Accepted command takes effect at that clock edge. cmd_ready = 1 in IDLE, RUN and ONESHOT; 0 in STEP.
- States:
  - IDLE: prescaler held at 0, no ticks.
  - RUN: prescaler 0..CLOCK_MHZ-1. tick asserted for one cycle when prescaler == CLOCK_MHZ-1. On that edge, count += 1 (up) or -= 1 (down), modulo 2^BITS.
  - ONESHOT: same as RUN. On the tick that wraps, state returns to IDLE; the wrapped value (0 up / max down) is kept.
  - STEP: counts exactly one tick (CLOCK_MHZ cycles from acceptance), then returns to IDLE.
- Transitions:
  - IDLE: START -> RUN; ONESHOT -> ONESHOT; STEP -> STEP. Prescaler starts at 0, so the first tick occurs CLOCK_MHZ cycles after acceptance.
  - RUN/ONESHOT: STOP -> IDLE, prescaler cleared.
  - START in RUN, or ONESHOT in ONESHOT: no effect; prescaler phase preserved.
  - START in ONESHOT -> RUN and vice versa, prescaler phase preserved.
  - STEP accepted in RUN/ONESHOT: ignored.
- LOAD, any accepting state: bin_out <= cmd_data, prescaler cleared, state unchanged, no wrap pulse.
- DIR, any accepting state: direction updated; prescaler untouched.
- Update timing: gray_out = next_bin ^ (next_bin >> 1), registered alongside bin_out. Count-to-output latency is 1 cycle after the tick edge; tick, the bin_out change and wrap all appear in the same cycle.
- Simultaneous accepted command and terminal count:
  - STOP or LOAD wins: no increment, no tick, no wrap.
  - DIR: the increment uses the old direction; the new direction applies from the next tick.
- Reset mid-operation: immediately returns everything to reset values. No partial tick.

Decomposition:
- Package gray_seq_pkg: opcode localparams (OP_NOP..OP_ONESHOT), state encoding (ST_IDLE, ST_RUN, ST_ONESHOT, ST_STEP), DIR_UP/DIR_DOWN.
- Sub-module tick_prescaler: inputs clk, rst_n, enable, clear; output tick. Wraps at CLOCK_MHZ-1.
- FSM, count and Gray registers stay in gray_counter_sequencer.

Test Plan:
- Reset mid-RUN at count 0x37 -> all outputs 0, state IDLE, cmd_ready 1 on the same edge (asynchronous).
- START from reset -> first tick 16 cycles after acceptance; bin_out 1, gray_out 0x01; after 3 ticks bin_out 3, gray_out 0x02; tick spacing exactly 16 cycles.
- LOAD 0xFE, ONESHOT -> bin 0xFF (gray 0x80), then bin 0x00, gray 0x00, wrap pulse; state returns to IDLE; no further ticks.
- DIR down, LOAD 0x00, STEP -> cmd_ready low 16 cycles; bin 0xFF, gray 0x80, wrap 1; state IDLE.
- In RUN, STOP presented exactly on the prescaler terminal cycle -> no tick, count unchanged, IDLE.
- In RUN, LOAD 0x10 on the terminal cycle -> bin 0x10, gray 0x18, no wrap; next tick 16 cycles later gives 0x11 / 0x19.
